// File: rtl/chg_pkg.sv
// rtl/chg_pkg.sv - charging result field widths, policy encodings, entry struct and helpers
package chg_pkg;

  localparam int CHG_ID_W     = 96;
  localparam int CHG_LEN_W    = 16;
  localparam int CHG_POL_W    = 3;
  localparam int CHG_REP_W    = 22;
  localparam int CHG_CNT_ID_W = 14;
  localparam int CHG_THR_W    = 6;
  localparam int CHG_RESULT_W = 139;

  localparam logic [CHG_POL_W-1:0] CHG_POL_DROP = 3'd1;
  localparam logic [CHG_POL_W-1:0] CHG_POL_HOST = 3'd2;
  localparam logic [CHG_POL_W-1:0] CHG_POL_FWD  = 3'd4;

  typedef struct packed {
    logic [CHG_REP_W-CHG_THR_W-CHG_CNT_ID_W-1:0] rsvd;
    logic [CHG_THR_W-1:0]                        thr_en;
    logic [CHG_CNT_ID_W-1:0]                     cnt_id;
  } chg_report_t;

  typedef struct packed {
    logic [CHG_ID_W-1:0]  pkt_id;
    logic [CHG_LEN_W-1:0] pkt_len;
    logic [CHG_POL_W-1:0] cnt_policy;
    chg_report_t          cnt_report;
    logic                 ul;
    logic                 cnt_en;
  } chg_result_t;

  function automatic logic [31:0] chg_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/chg_fifo_mem.sv
// rtl/chg_fifo_mem.sv - DEPTH x 139 result storage, synchronous write, asynchronous read
module chg_fifo_mem
  import chg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    asclk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [CHG_RESULT_W-1:0] wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic [CHG_RESULT_W-1:0] rd_data
);

  logic [CHG_RESULT_W-1:0] mem [DEPTH];

  always_ff @(posedge asclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/charging_result_fifo.sv
// rtl/charging_result_fifo.sv - FWFT elastic buffer for charging results
// Statistics counters are built only when CHG_RESULT_FIFO_STATS_EN is defined.
module charging_result_fifo
  import chg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 asclk,
  input  logic                 aresetn,
  input  logic [CHG_ID_W-1:0]  in_pkt_id,
  input  logic [CHG_LEN_W-1:0] in_pkt_len,
  input  logic [CHG_POL_W-1:0] in_cnt_policy,
  input  logic [CHG_REP_W-1:0] in_cnt_report,
  input  logic                 in_ul,
  input  logic                 in_cnt_en,
  input  logic                 in_vld,
  output logic                 in_rdy,
  output logic [CHG_ID_W-1:0]  out_pkt_id,
  output logic [CHG_LEN_W-1:0] out_pkt_len,
  output logic [CHG_POL_W-1:0] out_cnt_policy,
  output logic [CHG_REP_W-1:0] out_cnt_report,
  output logic                 out_ul,
  output logic                 out_cnt_en,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [AW:0]          level,
  output logic [31:0]          stall_count,
  output logic [AW:0]          peak_level,
  output logic [31:0]          drop_pkts,
  output logic [31:0]          host_pkts,
  output logic [31:0]          fwd_pkts,
  output logic                 policy_err
);

  logic [AW:0]             wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [AW:0]             level_q;
  logic                    in_rdy_q;
  logic                    push, pop, empty, full_nxt;
  chg_result_t             wr_entry, rd_entry;
  logic [CHG_RESULT_W-1:0] rd_bits;

  assign empty   = (wr_ptr == rd_ptr);
  assign out_vld = !empty;
  assign in_rdy  = in_rdy_q;
  assign level   = level_q;
  assign push    = in_vld && in_rdy_q;
  assign pop     = out_vld && out_rdy;

  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
  // in_rdy is registered from next-state fullness so out_rdy never reaches it combinationally
  assign full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                      (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);

  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_rdy_q <= 1'b0;
      level_q  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      in_rdy_q <= !full_nxt;
      if (push && !pop) begin
        level_q <= level_q + {{AW{1'b0}}, 1'b1};
      end else if (pop && !push) begin
        level_q <= level_q - {{AW{1'b0}}, 1'b1};
      end
    end
  end

  assign wr_entry.pkt_id     = in_pkt_id;
  assign wr_entry.pkt_len    = in_pkt_len;
  assign wr_entry.cnt_policy = in_cnt_policy;
  assign wr_entry.cnt_report = chg_report_t'(in_cnt_report);
  assign wr_entry.ul         = in_ul;
  assign wr_entry.cnt_en     = in_cnt_en;

  chg_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .asclk   (asclk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_bits)
  );

  assign rd_entry       = chg_result_t'(rd_bits);
  assign out_pkt_id     = rd_entry.pkt_id;
  assign out_pkt_len    = rd_entry.pkt_len;
  assign out_cnt_policy = rd_entry.cnt_policy;
  assign out_cnt_report = rd_entry.cnt_report;
  assign out_ul         = rd_entry.ul;
  assign out_cnt_en     = rd_entry.cnt_en;

`ifdef CHG_RESULT_FIFO_STATS_EN
  logic [31:0] stall_q, drop_q, host_q, fwd_q;
  logic [AW:0] peak_q;
  logic        perr_q;

  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      stall_q <= '0;
      drop_q  <= '0;
      host_q  <= '0;
      fwd_q   <= '0;
      peak_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      if (in_vld && !in_rdy_q) begin
        stall_q <= chg_sat_inc(stall_q);
      end
      if (level_q > peak_q) begin
        peak_q <= level_q;
      end
      if (push) begin
        case (in_cnt_policy)
          CHG_POL_DROP: drop_q <= chg_sat_inc(drop_q);
          CHG_POL_HOST: host_q <= chg_sat_inc(host_q);
          CHG_POL_FWD:  fwd_q  <= chg_sat_inc(fwd_q);
          default:      perr_q <= 1'b1;
        endcase
      end
    end
  end

  assign stall_count = stall_q;
  assign peak_level  = peak_q;
  assign drop_pkts   = drop_q;
  assign host_pkts   = host_q;
  assign fwd_pkts    = fwd_q;
  assign policy_err  = perr_q;
`else
  assign stall_count = '0;
  assign peak_level  = '0;
  assign drop_pkts   = '0;
  assign host_pkts   = '0;
  assign fwd_pkts    = '0;
  assign policy_err  = 1'b0;
`endif

endmodule

// File: tb/tb_charging_result_fifo.sv
// tb/tb_charging_result_fifo.sv - self-checking bench for charging_result_fifo
module tb_charging_result_fifo;
  import chg_pkg::*;

`ifdef CHG_RESULT_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        asclk = 1'b0;
  logic        aresetn;
  logic [95:0] in_pkt_id;
  logic [15:0] in_pkt_len;
  logic [2:0]  in_cnt_policy;
  logic [21:0] in_cnt_report;
  logic        in_ul, in_cnt_en, in_vld, in_rdy;
  logic [95:0] out_pkt_id;
  logic [15:0] out_pkt_len;
  logic [2:0]  out_cnt_policy;
  logic [21:0] out_cnt_report;
  logic        out_ul, out_cnt_en, out_vld, out_rdy;
  logic [4:0]  level, peak_level;
  logic [31:0] stall_count, drop_pkts, host_pkts, fwd_pkts;
  logic        policy_err;

  charging_result_fifo dut (
    .asclk(asclk), .aresetn(aresetn),
    .in_pkt_id(in_pkt_id), .in_pkt_len(in_pkt_len), .in_cnt_policy(in_cnt_policy),
    .in_cnt_report(in_cnt_report), .in_ul(in_ul), .in_cnt_en(in_cnt_en),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .out_pkt_id(out_pkt_id), .out_pkt_len(out_pkt_len), .out_cnt_policy(out_cnt_policy),
    .out_cnt_report(out_cnt_report), .out_ul(out_ul), .out_cnt_en(out_cnt_en),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .level(level), .stall_count(stall_count), .peak_level(peak_level),
    .drop_pkts(drop_pkts), .host_pkts(host_pkts), .fwd_pkts(fwd_pkts),
    .policy_err(policy_err)
  );

  always #5 asclk = ~asclk;

  int errors = 0;
  int checks = 0;

  logic [138:0] in_bits, head_bits, held_d, exp_d;
  logic         held_v = 1'b0;
  logic [138:0] sb[$];
  int           m_drop = 0, m_host = 0, m_fwd = 0;

  assign in_bits   = {in_pkt_id, in_pkt_len, in_cnt_policy, in_cnt_report, in_ul, in_cnt_en};
  assign head_bits = {out_pkt_id, out_pkt_len, out_cnt_policy, out_cnt_report, out_ul, out_cnt_en};

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge asclk);
    #1;
  endtask

  // Scoreboard: handshakes are sampled mid-cycle, ahead of the edge that completes them
  always @(negedge asclk) begin
    if (!aresetn) begin
      sb.delete();
      held_v = 1'b0;
      m_drop = 0; m_host = 0; m_fwd = 0;
    end else begin
      if (held_v) begin
        checks++;
        if (!(out_vld === 1'b1 && head_bits === held_d)) begin
          errors++;
          $display("FAIL head_stable: got vld=%0b %0h expected %0h", out_vld, head_bits, held_d);
        end
      end
      if (out_vld && out_rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %0h expected no entry", head_bits);
        end else begin
          exp_d = sb.pop_front();
          if (head_bits !== exp_d) begin
            errors++;
            $display("FAIL pop_data: got %0h expected %0h", head_bits, exp_d);
          end
        end
      end
      held_v = out_vld && !out_rdy;
      held_d = head_bits;
      if (in_vld && in_rdy) begin
        sb.push_back(in_bits);
        case (in_cnt_policy)
          3'd1: m_drop++;
          3'd2: m_host++;
          3'd4: m_fwd++;
          default: ;
        endcase
      end
    end
  end

  task automatic set_entry(input logic [95:0] id, input logic [2:0] pol);
    in_pkt_id     = id;
    in_pkt_len    = 16'd64;
    in_cnt_policy = pol;
    in_cnt_report = {8'h00, id[13:0]};
    in_ul         = id[0];
    in_cnt_en     = 1'b1;
  endtask

  task automatic rand_entry();
    in_pkt_id     = {$urandom, $urandom, $urandom};
    in_pkt_len    = 16'($urandom);
    in_cnt_policy = 3'(3'b001 << $urandom_range(0, 2));
    in_cnt_report = 22'($urandom);
    in_ul         = 1'($urandom);
    in_cnt_en     = 1'($urandom);
  endtask

  task automatic drain(input string nm);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < 64 && out_vld; i++) tick();
    chk({nm, "_empty"}, {95'd0, out_vld}, 96'd0);
    chk({nm, "_sb_empty"}, 96'(sb.size()), 96'd0);
    out_rdy = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [95:0] id;
    logic        e_in_rdy;
    logic        e_out_vld;
    logic [4:0]  e_level;
    logic [95:0] e_head;
  } vec_t;

  vec_t vt[4];
  logic [7:0] lfsr;
  logic       acc;
  int         pushed, cyc, snap_fwd;

  initial begin
    vt[0] = '{1'b1, 1'b1, 96'd1, 1'b1, 1'b1, 5'd1, 96'd1};
    vt[1] = '{1'b1, 1'b1, 96'd2, 1'b1, 1'b1, 5'd1, 96'd2};
    vt[2] = '{1'b1, 1'b1, 96'd3, 1'b1, 1'b1, 5'd1, 96'd3};
    vt[3] = '{1'b0, 1'b1, 96'd0, 1'b1, 1'b0, 5'd0, 96'd0};

    aresetn = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    set_entry(96'd0, 3'd4);
    repeat (3) tick();
    chk("rst_in_rdy", {95'd0, in_rdy}, 96'd0);
    chk("rst_out_vld", {95'd0, out_vld}, 96'd0);
    chk("rst_level", 96'(level), 96'd0);
    chk("rst_stats", {stall_count, drop_pkts, host_pkts[15:0], fwd_pkts[14:0], policy_err},
        96'd0);
    chk("rst_peak", 96'(peak_level), 96'd0);
    aresetn = 1'b1;
    tick();
    chk("rst_in_rdy_rise", {95'd0, in_rdy}, 96'd1);

    for (int i = 0; i < 4; i++) begin
      in_vld  = vt[i].iv;
      out_rdy = vt[i].ordy;
      set_entry(vt[i].id, 3'd4);
      tick();
      chk($sformatf("vec%0d_in_rdy", i), {95'd0, in_rdy}, {95'd0, vt[i].e_in_rdy});
      chk($sformatf("vec%0d_out_vld", i), {95'd0, out_vld}, {95'd0, vt[i].e_out_vld});
      chk($sformatf("vec%0d_level", i), 96'(level), 96'(vt[i].e_level));
      if (vt[i].e_out_vld) chk($sformatf("vec%0d_head", i), out_pkt_id, vt[i].e_head);
    end
    chk("fwd_after_3", 96'(fwd_pkts), STATS ? 96'd3 : 96'd0);

    // Fill to DEPTH, then hold a 17th request against a full FIFO
    out_rdy = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_vld = 1'b1;
      set_entry(96'(100 + k), 3'd4);
      tick();
    end
    chk("full_in_rdy", {95'd0, in_rdy}, 96'd0);
    chk("full_level", 96'(level), 96'd16);
    set_entry(96'd200, 3'd4);
    repeat (5) tick();
    chk("stall_count", 96'(stall_count), STATS ? 96'd5 : 96'd0);
    chk("peak_level", 96'(peak_level), STATS ? 96'd16 : 96'd0);
    chk("full_hold_level", 96'(level), 96'd16);

    out_rdy = 1'b1;
    tick();
    chk("full_pop_level", 96'(level), 96'd15);
    chk("full_pop_in_rdy", {95'd0, in_rdy}, 96'd1);
    out_rdy = 1'b0;
    tick();
    chk("refill_level", 96'(level), 96'd16);
    chk("refill_in_rdy", {95'd0, in_rdy}, 96'd0);
    drain("drain_full");

    lfsr = 8'hA5; pushed = 0; cyc = 0;
    rand_entry();
    in_vld = 1'b1;
    out_rdy = lfsr[0];
    while (pushed < 10000 && cyc < 60000) begin
      acc = in_rdy;
      tick();
      cyc++;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      out_rdy = lfsr[0];
      if (acc) begin
        pushed++;
        if (pushed < 10000) rand_entry();
        else in_vld = 1'b0;
      end
    end
    chk("lfsr_pushed", 96'(pushed), 96'd10000);
    drain("drain_lfsr");
    chk("drop_pkts", 96'(drop_pkts), STATS ? 96'(m_drop) : 96'd0);
    chk("host_pkts", 96'(host_pkts), STATS ? 96'(m_host) : 96'd0);
    chk("fwd_pkts", 96'(fwd_pkts), STATS ? 96'(m_fwd) : 96'd0);

    snap_fwd = m_fwd;
    out_rdy = 1'b1; in_vld = 1'b1;
    set_entry(96'd300, 3'd3);
    tick();
    in_vld = 1'b0;
    tick();
    chk("policy_err_set", {95'd0, policy_err}, {95'd0, STATS});
    chk("policy_err_fwd", 96'(fwd_pkts), STATS ? 96'(snap_fwd) : 96'd0);
    chk("policy_err_drop", 96'(drop_pkts), STATS ? 96'(m_drop) : 96'd0);
    in_vld = 1'b1;
    set_entry(96'd301, 3'd1);
    tick();
    in_vld = 1'b0;
    tick();
    chk("policy_err_sticky", {95'd0, policy_err}, {95'd0, STATS});
    chk("drop_after_valid", 96'(drop_pkts), STATS ? 96'(m_drop) : 96'd0);
    drain("drain_pol");

    out_rdy = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_vld = 1'b1;
      set_entry(96'(400 + k), 3'd2);
      tick();
    end
    in_vld = 1'b0;
    chk("pre_rst_level", 96'(level), 96'd7);
    aresetn = 1'b0;
    tick();
    chk("mid_rst_out_vld", {95'd0, out_vld}, 96'd0);
    chk("mid_rst_level", 96'(level), 96'd0);
    chk("mid_rst_in_rdy", {95'd0, in_rdy}, 96'd0);
    chk("mid_rst_policy_err", {95'd0, policy_err}, 96'd0);
    aresetn = 1'b1;
    tick();
    chk("mid_rst_in_rdy_rise", {95'd0, in_rdy}, 96'd1);
    chk("mid_rst_out_vld_hold", {95'd0, out_vld}, 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
